mod_sum_accumulator: RTL and testbench



---
 rtl/mod_acc_pkg.sv | 20 ++
 rtl/carry_step_Modu_adder.sv | 31 +++
 rtl/mod_sum_accumulator.sv | 110 +++++++++++
 tb/tb_mod_sum_accumulator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_acc_pkg.sv
// Shared types and helpers for mod_sum_accumulator.
package mod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned ADDER_WIDTH = 32;

  // Increment that sticks at 2^w-1 once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    if (w >= 32) maxv = '1;
    else         maxv = (32'd1 << w) - 32'd1;
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/carry_step_Modu_adder.sv
// 32-bit modulo carry-select adder; carry-out of the top block is discarded.
module carry_step_Modu_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam int unsigned NB = WIDTH / BLK;

  logic [NB-1:0] c;
  assign c[0] = 1'b0;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLK-1:0] a_b, b_b;
    assign a_b = a_i[g*BLK +: BLK];
    assign b_b = b_i[g*BLK +: BLK];
    if (g < NB - 1) begin : g_mid
      logic [BLK:0] s0, s1;
      assign s0 = {1'b0, a_b} + {1'b0, b_b};
      assign s1 = {1'b0, a_b} + {1'b0, b_b} + (BLK+1)'(1);
      assign sum_o[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
      assign c[g+1]              = c[g] ? s1[BLK]     : s0[BLK];
    end else begin : g_top
      assign sum_o[g*BLK +: BLK] = c[g] ? (a_b + b_b + BLK'(1)) : (a_b + b_b);
    end
  end

endmodule

// File: rtl/mod_sum_accumulator.sv
// Framed modulo-2^32 stream accumulator around carry_step_Modu_adder.
// Optional MOD_ACC_WRAP_FLAG_EN adds out_wrap, a per-frame sticky wrap flag.
module mod_sum_accumulator
  import mod_acc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count
`ifdef MOD_ACC_WRAP_FLAG_EN
  ,
  output logic               out_wrap
`endif
);

  if (WIDTH != ADDER_WIDTH) begin : g_width_chk
    $error("mod_sum_accumulator: WIDTH must be 32");
  end

  state_t              state_q;
  logic [WIDTH-1:0]    acc_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic [COUNT_W-1:0]  cnt_d;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    sum;
  logic                accept;
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_sum_q;
  logic [COUNT_W-1:0]  out_count_q;

  assign in_ready = ~rst & (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  // IDLE forces operand A and the count base to zero, so a new frame needs no clear cycle.
  assign op_a     = (state_q == IDLE) ? '0 : acc_q;
  assign cnt_d    = COUNT_W'(sat_inc(32'((state_q == IDLE) ? '0 : cnt_q), COUNT_W));

  carry_step_Modu_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (op_a),
    .b_i   (in_data),
    .sum_o (sum)
  );

`ifdef MOD_ACC_WRAP_FLAG_EN
  logic wrap_q, wrap_d, out_wrap_q;
  assign wrap_d   = ((state_q == IDLE) ? 1'b0 : wrap_q) | (sum < op_a);
  assign out_wrap = out_wrap_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
`ifdef MOD_ACC_WRAP_FLAG_EN
      wrap_q      <= 1'b0;
      out_wrap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_sum_q   <= sum;
              out_count_q <= cnt_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
              acc_q       <= '0;
              cnt_q       <= '0;
`ifdef MOD_ACC_WRAP_FLAG_EN
              out_wrap_q  <= wrap_d;
              wrap_q      <= 1'b0;
`endif
            end else begin
              acc_q   <= sum;
              cnt_q   <= cnt_d;
              state_q <= ACCUM;
`ifdef MOD_ACC_WRAP_FLAG_EN
              wrap_q  <= wrap_d;
`endif
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_mod_sum_accumulator.sv
// Bench for mod_sum_accumulator: directed frames from the test plan plus random frames.
module tb_mod_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
`ifdef MOD_ACC_WRAP_FLAG_EN
  logic        out_wrap;
`endif

  int checks = 0;
  int passed = 0;

  mod_sum_accumulator #(.WIDTH(32), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
`ifdef MOD_ACC_WRAP_FLAG_EN
    ,
    .out_wrap  (out_wrap)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: modular sum via wide arithmetic, saturating length, wrap if any partial sum overflowed.
  function automatic void model(input logic [31:0] d[$], output logic [31:0] s,
                                output logic [7:0] c, output logic w);
    longint unsigned acc = 0;
    w = 1'b0;
    foreach (d[i]) begin
      acc += longint'(d[i]);
      if (acc >= 64'h1_0000_0000) begin
        w = 1'b1;
        acc -= 64'h1_0000_0000;
      end
    end
    s = acc[31:0];
    c = (d.size() > 255) ? 8'd255 : 8'(d.size());
  endfunction

  task automatic run_frame(input string tag, input logic [31:0] d[$], input int gap_pct,
                           input int stall, input bit keep_valid);
    logic [31:0] es;
    logic [7:0]  ec;
    logic        ew;
    int          n;
    model(d, es, ec, ew);
    out_ready = (stall == 0);
    for (int i = 0; i < d.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = d[i];
      in_last  = (i == d.size() - 1);
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) chk({tag, "_ready_timeout"}, in_ready, 1);
      if (i == d.size() - 1) chk({tag, "_pre_valid"}, out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_count"}, out_count, ec);
`ifdef MOD_ACC_WRAP_FLAG_EN
    chk({tag, "_wrap"}, out_wrap, ew);
`endif
    for (int k = 0; k < stall; k++) begin
      if (keep_valid) begin
        in_valid = 1'b1;
        in_data  = 32'h7;
        in_last  = 1'b1;
      end
      tick();
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sum"}, out_sum, es);
      chk({tag, "_hold_count"}, out_count, ec);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q[$];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
`ifdef MOD_ACC_WRAP_FLAG_EN
    chk("rst_out_wrap", out_wrap, 0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    q = '{32'h1, 32'h2, 32'h3};
    run_frame("f3", q, 0, 0, 1'b0);
    chk("f3_abs_sum", out_sum, 32'h6);

    q = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_frame("fwrap", q, 0, 0, 1'b0);
    chk("fwrap_abs_sum", out_sum, 32'h1);

    q = '{32'hDEAD_BEEF};
    run_frame("single", q, 0, 0, 1'b0);

    q = '{32'h11, 32'h22};
    run_frame("hold", q, 0, 5, 1'b1);
    q = '{32'h7};
    run_frame("after_hold", q, 0, 0, 1'b0);

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(32'h1);
    run_frame("sat300", q, 0, 0, 1'b0);
    chk("sat300_abs_sum", out_sum, 32'h12C);

    // Partial frame abandoned by reset.
    in_valid = 1'b1; in_last = 1'b0; in_data = 32'h10;
    tick();
    in_data = 32'h20;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    chk("midrst_no_stale", out_valid, 0);
    q = '{32'h5};
    run_frame("midrst_frame", q, 0, 0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
      run_frame($sformatf("rnd%0d", f), q, 30, $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
